// File: rtl/alu_issue_unit.sv
// Issue/response sequencer between a valid/ready request port and an external ALU.
// Optional macro ALU_ISSUE_PIPE_EN lets RESP hand over straight to the next request.
module alu_issue_unit #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FPU_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_vld,
    output logic             req_rdy,
    input  logic [3:0]       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_res,
    input  logic             alu_zero,
    input  logic             alu_ovf,
    output logic             rsp_vld,
    input  logic             rsp_rdy,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             busy
);

    localparam logic [3:0] CntInit = 4'(FPU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StFwait, StResp} state_e;

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] data_q;
    logic             zero_q, ovf_q;

    logic accept;
    logic capture;
    logic req_is_fpu;

    assign req_is_fpu = (req_op[3:1] == 3'b111);

    // Qualified with rst so the port reads 0 while reset is held.
`ifdef ALU_ISSUE_PIPE_EN
    assign req_rdy = !rst && ((state_q == StIdle) || (state_q == StResp && rsp_rdy));
`else
    assign req_rdy = !rst && (state_q == StIdle);
`endif

    assign accept = req_vld && req_rdy;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        capture = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_is_fpu ? StFwait : StExec;
                    cnt_d   = req_is_fpu ? CntInit : 4'd0;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StFwait: begin
                if (cnt_q == 4'd0) begin
                    capture = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StResp: begin
                if (rsp_rdy) begin
                    state_d = StIdle;
                    if (accept) begin
                        state_d = req_is_fpu ? StFwait : StExec;
                        cnt_d   = req_is_fpu ? CntInit : 4'd0;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            a_q     <= '0;
            b_q     <= '0;
            data_q  <= '0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                op_q <= req_op;
                a_q  <= req_a;
                b_q  <= req_b;
            end
            if (capture) begin
                data_q <= alu_res;
                zero_q <= alu_zero;
                // Overflow is only meaningful for FPU ops.
                ovf_q  <= (state_q == StFwait) ? alu_ovf : 1'b0;
            end
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = op_q;
    assign rsp_vld  = (state_q == StResp);
    assign rsp_data = data_q;
    assign rsp_zero = zero_q;
    assign rsp_ovf  = ovf_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand and result width.
REQ-002 The block SHALL have parameter FPU_LAT, default 2, legal range 1..15, giving the clocks an FPU op (ctrl 4'b1110/4'b1111) is held on the ALU.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with these ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active high
- req_vld  in  1  request valid
- req_rdy  out  1  request ready
- req_op  in  4  ALU control code
- req_a, req_b  in  WIDTH  operands
- alu_a, alu_b  out  WIDTH  operands driven to the ALU
- alu_ctrl  out  4  control driven to the ALU
- alu_res  in  WIDTH  ALU result
- alu_zero  in  1  ALU zero flag
- alu_ovf  in  1  FPU overflow from the ALU
- rsp_vld  out  1  response valid
- rsp_rdy  in  1  response ready
- rsp_data  out  WIDTH  captured result
- rsp_zero  out  1  captured zero flag
- rsp_ovf  out  1  captured overflow
- busy  out  1  high in any state other than IDLE

Function
REQ-004 The FSM SHALL have four states: IDLE, EXEC, FWAIT and RESP.
REQ-005 req_rdy SHALL be high in IDLE; a request is accepted on a rising edge where req_vld && req_rdy.
REQ-006 On acceptance the block SHALL register req_op, req_a and req_b, then drive them unchanged on alu_ctrl, alu_a and alu_b until the result is captured.
REQ-007 For an accepted op other than 1110/1111, the state SHALL go to EXEC; the next edge SHALL capture alu_res and alu_zero, set rsp_ovf=0, and go to RESP.
REQ-008 For an accepted op 1110/1111, the state SHALL go to FWAIT with a counter loaded to FPU_LAT-1.
- Each FWAIT edge decrements the counter.
- The edge on which the counter is 0 SHALL capture alu_res, alu_zero and alu_ovf, and go to RESP.
REQ-009 rsp_vld SHALL be high exactly while the state is RESP; rsp_data, rsp_zero and rsp_ovf SHALL be stable while rsp_vld is high.
REQ-010 In RESP, an edge with rsp_rdy=1 SHALL complete the response and go to IDLE; with rsp_rdy=0 the state SHALL hold indefinitely.
REQ-011 Latency from the accepting edge to rsp_vld high SHALL be 1 clock for integer ops and FPU_LAT clocks for FPU ops.
REQ-012 Undefined codes 1010..1101 SHALL be treated as integer ops; the response carries whatever alu_res returns, 0 for the current ALU.
REQ-013 alu_a, alu_b and alu_ctrl SHALL hold their last values in IDLE and RESP; they change only on acceptance.
REQ-014 req_vld asserted in EXEC or FWAIT SHALL be ignored: req_rdy=0 there and no operand register changes.

Reset
REQ-015 Asserting rst SHALL immediately set: state IDLE, counter 0, and all of req_rdy=0 (1 after release), rsp_vld, rsp_data, rsp_zero, rsp_ovf, alu_a, alu_b, alu_ctrl and busy to 0.
REQ-016 Reset asserted mid-operation (EXEC, FWAIT or RESP) SHALL discard the operation; no response is produced for it after release.

Configuration
REQ-017 With macro ALU_ISSUE_PIPE_EN defined, req_rdy SHALL also be high in RESP while rsp_rdy=1, so one edge can complete a response and accept a new request (RESP to EXEC/FWAIT, no IDLE cycle).
REQ-018 Without ALU_ISSUE_PIPE_EN, req_rdy SHALL be high only in IDLE, and back-to-back requests have at least one IDLE cycle between them.

Verification
REQ-019 ADD 0x0003+0x0004 with rsp_rdy=1 -> rsp_vld 1 clock after accept; rsp_data=0x0007, rsp_zero=0, rsp_ovf=0.
REQ-020 SUB 0x0005-0x0005 -> rsp_data=0x0000, rsp_zero=1.
REQ-021 FPU op 1111, FPU_LAT=2, ALU model returns 0x4200 with ovf=1 -> rsp_vld exactly 2 clocks after accept; rsp_data=0x4200, rsp_ovf=1.
REQ-022 rsp_rdy held 0 for 5 clocks after rsp_vld rises -> rsp_vld and rsp_data stable throughout; req_rdy=0 (macro off); completion on the first rsp_rdy=1 edge.
REQ-023 rst pulsed in FWAIT -> all outputs 0 at once; no rsp_vld after release; the next request completes normally.
REQ-024 Two back-to-back ADD requests with rsp_rdy=1 -> with ALU_ISSUE_PIPE_EN, responses 2 clocks apart; without it, 3 clocks apart.
